e203_fpu_disp: RTL and testbench

- FPU dispatch stage directly downstream of the FPU decoder.
- Accepts one decoded FP instruction per handshake: ftype, rounding mode, register enables/indices, and fp/int register-class flags.
- Resolves dynamic rounding mode, reads operands, and blocks RAW/WAW hazards using a 32-entry FP-register scoreboard.
- Holds the op in a single output register until the FPU execution unit takes it, and limits outstanding ops to OUTS_NUM.

---
 rtl/e203_fpu_disp_pkg.sv | 58 +++++
 rtl/e203_fpu_scbd.sv | 42 ++++
 rtl/e203_fpu_disp.sv | 170 +++++++++++++++++
 tb/tb_e203_fpu_disp.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/e203_fpu_disp_pkg.sv
// Shared encodings for the FPU dispatch slice: op types, rounding modes and the
// outstanding-op limit.
package e203_fpu_disp_pkg;

  localparam int unsigned E203_FPU_OUTS_NUM = 2;

  typedef enum logic [4:0] {
    FtFadd    = 5'd0,
    FtFsub    = 5'd1,
    FtFmul    = 5'd2,
    FtFdiv    = 5'd3,
    FtFsqrt   = 5'd4,
    FtFmadd   = 5'd5,
    FtFmsub   = 5'd6,
    FtFnmsub  = 5'd7,
    FtFnmadd  = 5'd8,
    FtFsgnj   = 5'd9,
    FtFsgnjn  = 5'd10,
    FtFsgnjx  = 5'd11,
    FtFmin    = 5'd12,
    FtFmax    = 5'd13,
    FtFcvtWS  = 5'd14,
    FtFcvtWuS = 5'd15,
    FtFmvXW   = 5'd16,
    FtFeq     = 5'd17,
    FtFlt     = 5'd18,
    FtFle     = 5'd19,
    FtFclass  = 5'd20,
    FtFcvtSW  = 5'd21,
    FtFcvtSWu = 5'd22,
    FtFmvWX   = 5'd23,
    FtFlw     = 5'd24,
    FtFsw     = 5'd25,
    FtInvalid = 5'd31
  } fpu_ftype_e;

  typedef enum logic [2:0] {
    RmRne = 3'b000,
    RmRtz = 3'b001,
    RmRdn = 3'b010,
    RmRup = 3'b011,
    RmRmm = 3'b100,
    RmDyn = 3'b111
  } fpu_rm_e;

  // Ops that never round ignore the rm field, so a reserved rm is not illegal for them.
  function automatic logic ftype_uses_rm(input logic [4:0] ftype);
    logic uses;
    uses = 1'b1;
    case (ftype)
      FtFsgnj, FtFsgnjn, FtFsgnjx, FtFmin, FtFmax, FtFmvXW, FtFeq, FtFlt, FtFle,
      FtFclass, FtFmvWX, FtFlw, FtFsw: uses = 1'b0;
      default: uses = 1'b1;
    endcase
    return uses;
  endfunction

endpackage

// File: rtl/e203_fpu_scbd.sv
// 32-entry FP register pending scoreboard. Reads return the pending state with a
// same-cycle writeback already removed; a same-index set and clear leaves the bit set.
module e203_fpu_scbd (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_en_i,
  input  logic [4:0] set_idx_i,
  input  logic       clr_en_i,
  input  logic [4:0] clr_idx_i,
  input  logic [4:0] rs1idx_i,
  input  logic [4:0] rs2idx_i,
  input  logic [4:0] rs3idx_i,
  input  logic [4:0] rdidx_i,
  output logic       rs1_pend_o,
  output logic       rs2_pend_o,
  output logic       rs3_pend_o,
  output logic       rd_pend_o
);

  logic [31:0] pend_q, pend_d;
  logic [31:0] set_vec, clr_vec, pend_eff;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en_i) set_vec[set_idx_i] = 1'b1;
    if (clr_en_i) clr_vec[clr_idx_i] = 1'b1;
    pend_eff = pend_q & ~clr_vec;
    pend_d   = pend_eff | set_vec;
  end

  assign rs1_pend_o = pend_eff[rs1idx_i];
  assign rs2_pend_o = pend_eff[rs2idx_i];
  assign rs3_pend_o = pend_eff[rs3idx_i];
  assign rd_pend_o  = pend_eff[rdidx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

endmodule

// File: rtl/e203_fpu_disp.sv
// FPU dispatch: resolves rounding mode, reads operands, stalls on FP register hazards
// and outstanding-op limit, and holds one op until the FPU execution unit takes it.
module e203_fpu_disp
  import e203_fpu_disp_pkg::*;
#(
  parameter int unsigned FLEN     = 32,
  parameter int unsigned OUTS_NUM = E203_FPU_OUTS_NUM,
  parameter int unsigned CNT_W    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic [4:0]      i_ftype,
  input  logic [2:0]      i_rm,
  input  logic            i_rs1en,
  input  logic            i_rs2en,
  input  logic            i_rs3en,
  input  logic            i_rdwen,
  input  logic [4:0]      i_rs1idx,
  input  logic [4:0]      i_rs2idx,
  input  logic [4:0]      i_rs3idx,
  input  logic [4:0]      i_rdidx,
  input  logic            i_rs1fpu,
  input  logic            i_rs2fpu,
  input  logic            i_rs3fpu,
  input  logic            i_rdfpu,
  input  logic [FLEN-1:0] i_int_rs1,
  input  logic [2:0]      csr_frm,
  output logic [4:0]      frf_rs1idx,
  output logic [4:0]      frf_rs2idx,
  output logic [4:0]      frf_rs3idx,
  input  logic [FLEN-1:0] frf_rs1_data,
  input  logic [FLEN-1:0] frf_rs2_data,
  input  logic [FLEN-1:0] frf_rs3_data,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [4:0]      o_ftype,
  output logic [2:0]      o_rm,
  output logic [FLEN-1:0] o_op1,
  output logic [FLEN-1:0] o_op2,
  output logic [FLEN-1:0] o_op3,
  output logic [4:0]      o_rdidx,
  output logic            o_rdwen,
  output logic            o_rdfpu,
  output logic            o_ill,
  input  logic            wbck_valid,
  input  logic [4:0]      wbck_rdidx,
  input  logic            wbck_rdfpu,
  input  logic            wbck_rdwen,
  input  logic            flush,
  output logic            fpu_busy
);

  logic            valid_q, valid_d;
  logic [4:0]      ftype_q, rdidx_q;
  logic [2:0]      rm_q;
  logic [FLEN-1:0] op1_q, op2_q, op3_q;
  logic            rdwen_q, rdfpu_q, ill_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]  cnt_plus;

  logic       issue, issue_ok, accept, held_pend, hazard, cnt_avail;
  logic       set_en, clr_en;
  logic       rs1_sb, rs2_sb, rs3_sb, rd_sb;
  logic       rs1_pend, rs2_pend, rs3_pend, rd_pend;
  logic [2:0] rm_res;
  logic       ill_new;

  assign frf_rs1idx = i_rs1idx;
  assign frf_rs2idx = i_rs2idx;
  assign frf_rs3idx = i_rs3idx;

  assign issue     = valid_q & o_ready;
  assign issue_ok  = issue & ~ill_q;
  assign held_pend = valid_q & rdwen_q & rdfpu_q & ~ill_q;
  assign set_en    = issue_ok & rdwen_q & rdfpu_q;
  assign clr_en    = wbck_valid & wbck_rdwen & wbck_rdfpu;

  e203_fpu_scbd u_scbd (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (set_en),
    .set_idx_i  (rdidx_q),
    .clr_en_i   (clr_en),
    .clr_idx_i  (wbck_rdidx),
    .rs1idx_i   (i_rs1idx),
    .rs2idx_i   (i_rs2idx),
    .rs3idx_i   (i_rs3idx),
    .rdidx_i    (i_rdidx),
    .rs1_pend_o (rs1_sb),
    .rs2_pend_o (rs2_sb),
    .rs3_pend_o (rs3_sb),
    .rd_pend_o  (rd_sb)
  );

  // The held op is not in the scoreboard yet but must still block its consumers.
  always_comb begin
    rs1_pend = rs1_sb | (held_pend & (i_rs1idx == rdidx_q));
    rs2_pend = rs2_sb | (held_pend & (i_rs2idx == rdidx_q));
    rs3_pend = rs3_sb | (held_pend & (i_rs3idx == rdidx_q));
    rd_pend  = rd_sb  | (held_pend & (i_rdidx  == rdidx_q));
    hazard   = (i_rs1en & i_rs1fpu & rs1_pend) | (i_rs2en & i_rs2fpu & rs2_pend) |
               (i_rs3en & i_rs3fpu & rs3_pend) | (i_rdwen & i_rdfpu & rd_pend);
  end

  always_comb begin
    cnt_plus  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, issue_ok};
    cnt_avail = cnt_plus < OUTS_NUM[CNT_W:0];
    // Underflow is a protocol error; hold at zero rather than wrap.
    if (wbck_valid && (cnt_plus != '0)) cnt_d = CNT_W'(cnt_plus - 1'b1);
    else                                cnt_d = CNT_W'(cnt_plus);
  end

  assign i_ready  = ~flush & ~hazard & cnt_avail & (~valid_q | o_ready);
  assign accept   = i_valid & i_ready;
  assign fpu_busy = valid_q | (cnt_q != '0);

  always_comb begin
    rm_res  = (i_rm == RmDyn) ? csr_frm : i_rm;
    ill_new = (ftype_uses_rm(i_ftype) & (rm_res inside {3'b101, 3'b110, 3'b111})) |
              (i_ftype == FtInvalid);
    valid_d = accept | (valid_q & ~issue & ~flush);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      ftype_q <= '0;
      rm_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      op3_q   <= '0;
      rdidx_q <= '0;
      rdwen_q <= 1'b0;
      rdfpu_q <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        ftype_q <= i_ftype;
        rm_q    <= rm_res;
        op1_q   <= i_rs1fpu ? frf_rs1_data : i_int_rs1;
        op2_q   <= i_rs2fpu ? frf_rs2_data : '0;
        op3_q   <= i_rs3fpu ? frf_rs3_data : '0;
        rdidx_q <= i_rdidx;
        rdwen_q <= i_rdwen;
        rdfpu_q <= i_rdfpu;
        ill_q   <= ill_new;
      end
    end
  end

  assign o_valid = valid_q;
  assign o_ftype = ftype_q;
  assign o_rm    = rm_q;
  assign o_op1   = op1_q;
  assign o_op2   = op2_q;
  assign o_op3   = op3_q;
  assign o_rdidx = rdidx_q;
  assign o_rdwen = rdwen_q;
  assign o_rdfpu = rdfpu_q;
  assign o_ill   = ill_q;

  wbck_underflow: assert property (@(posedge clk) disable iff (rst)
    !(wbck_valid && (cnt_q == '0)));

endmodule

// File: tb/tb_e203_fpu_disp.sv
// Random-stimulus bench for e203_fpu_disp: an in-order FPU model plus a queue of
// expected dispatched ops checked by an independent output monitor.
module tb_e203_fpu_disp;
  import e203_fpu_disp_pkg::*;

  logic        clk, rst;
  logic        i_valid, i_ready;
  logic [4:0]  i_ftype;
  logic [2:0]  i_rm, csr_frm;
  logic        i_rs1en, i_rs2en, i_rs3en, i_rdwen;
  logic [4:0]  i_rs1idx, i_rs2idx, i_rs3idx, i_rdidx;
  logic        i_rs1fpu, i_rs2fpu, i_rs3fpu, i_rdfpu;
  logic [31:0] i_int_rs1;
  logic [4:0]  frf_rs1idx, frf_rs2idx, frf_rs3idx;
  logic [31:0] frf_rs1_data, frf_rs2_data, frf_rs3_data;
  logic        o_valid, o_ready;
  logic [4:0]  o_ftype, o_rdidx;
  logic [2:0]  o_rm;
  logic [31:0] o_op1, o_op2, o_op3;
  logic        o_rdwen, o_rdfpu, o_ill;
  logic        wbck_valid, wbck_rdfpu, wbck_rdwen, flush, fpu_busy;
  logic [4:0]  wbck_rdidx;

  e203_fpu_disp #(.FLEN(32), .OUTS_NUM(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready), .i_ftype(i_ftype),
    .i_rm(i_rm), .i_rs1en(i_rs1en), .i_rs2en(i_rs2en), .i_rs3en(i_rs3en),
    .i_rdwen(i_rdwen), .i_rs1idx(i_rs1idx), .i_rs2idx(i_rs2idx), .i_rs3idx(i_rs3idx),
    .i_rdidx(i_rdidx), .i_rs1fpu(i_rs1fpu), .i_rs2fpu(i_rs2fpu), .i_rs3fpu(i_rs3fpu),
    .i_rdfpu(i_rdfpu), .i_int_rs1(i_int_rs1), .csr_frm(csr_frm),
    .frf_rs1idx(frf_rs1idx), .frf_rs2idx(frf_rs2idx), .frf_rs3idx(frf_rs3idx),
    .frf_rs1_data(frf_rs1_data), .frf_rs2_data(frf_rs2_data), .frf_rs3_data(frf_rs3_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_ftype(o_ftype), .o_rm(o_rm),
    .o_op1(o_op1), .o_op2(o_op2), .o_op3(o_op3), .o_rdidx(o_rdidx), .o_rdwen(o_rdwen),
    .o_rdfpu(o_rdfpu), .o_ill(o_ill), .wbck_valid(wbck_valid), .wbck_rdidx(wbck_rdidx),
    .wbck_rdfpu(wbck_rdfpu), .wbck_rdwen(wbck_rdwen), .flush(flush), .fpu_busy(fpu_busy)
  );

  typedef struct {
    logic [4:0]  ftype;
    logic [2:0]  rm;
    logic [31:0] op1, op2, op3;
    logic [4:0]  rdidx;
    logic        rdwen, rdfpu, ill;
  } exp_t;

  typedef struct {
    logic [4:0] rdidx;
    logic       rdwen, rdfpu;
  } inf_t;

  exp_t exp_q[$];   // head is the op currently held by the dispatcher
  inf_t infl[$];    // ops issued to the FPU, oldest first
  bit   held_v;
  bit   wb_now;
  int   checks, failures;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit rounds(input logic [4:0] ft);
    return ft inside {FtFadd, FtFsub, FtFmul, FtFdiv, FtFsqrt, FtFmadd, FtFmsub, FtFnmsub,
                      FtFnmadd, FtFcvtWS, FtFcvtWuS, FtFcvtSW, FtFcvtSWu};
  endfunction

  // A register is busy while an un-retired FP write to it exists (issued or held).
  function automatic bit busy(input logic [4:0] r);
    for (int i = 0; i < infl.size(); i++)
      if (!(i == 0 && wb_now) && infl[i].rdwen && infl[i].rdfpu && infl[i].rdidx == r)
        return 1'b1;
    if (held_v && exp_q.size() != 0 && exp_q[0].rdwen && exp_q[0].rdfpu && !exp_q[0].ill &&
        exp_q[0].rdidx == r)
      return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output monitor: every issue handshake retires the oldest expected op.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          chk("issue_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("o_ftype", o_ftype, e.ftype);
          chk("o_rm", o_rm, e.rm);
          chk("o_op1", o_op1, e.op1);
          chk("o_op2", o_op2, e.op2);
          chk("o_op3", o_op3, e.op3);
          chk("o_rd", {o_rdidx, o_rdwen, o_rdfpu}, {e.rdidx, e.rdwen, e.rdfpu});
          chk("o_ill", o_ill, e.ill);
        end
      end
    end
  end

  initial begin
    bit   exp_rdy, hazard, acc;
    int   cnt_after;
    exp_t e;
    checks = 0; failures = 0; held_v = 0; wb_now = 0;
    rst = 1'b1;
    {i_valid, i_ftype, i_rm, csr_frm, i_rs1en, i_rs2en, i_rs3en, i_rdwen} = '0;
    {i_rs1idx, i_rs2idx, i_rs3idx, i_rdidx, i_rs1fpu, i_rs2fpu, i_rs3fpu, i_rdfpu} = '0;
    {i_int_rs1, frf_rs1_data, frf_rs2_data, frf_rs3_data} = '0;
    {o_ready, wbck_valid, wbck_rdidx, wbck_rdfpu, wbck_rdwen, flush} = '0;
    repeat (3) @(negedge clk);
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_fpu_busy", fpu_busy, 1'b0);
    chk("rst_o_data", o_op1 | o_op2 | o_op3, 32'd0);
    chk("rst_o_fields", {o_ftype, o_rm, o_rdidx, o_rdwen, o_rdfpu, o_ill}, '0);
    rst = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      i_valid  = $urandom_range(0, 99) < 70;
      i_ftype  = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 25));
      i_rm     = 3'($urandom_range(0, 7));
      csr_frm  = 3'($urandom_range(0, 7));
      {i_rs1en, i_rs2en, i_rs3en, i_rdwen}    = 4'($urandom);
      {i_rs1fpu, i_rs2fpu, i_rs3fpu, i_rdfpu} = 4'($urandom);
      i_rs1idx = 5'($urandom_range(0, 7));
      i_rs2idx = 5'($urandom_range(0, 7));
      i_rs3idx = 5'($urandom_range(0, 7));
      i_rdidx  = 5'($urandom_range(0, 7));
      i_int_rs1    = $urandom;
      frf_rs1_data = $urandom;
      frf_rs2_data = $urandom;
      frf_rs3_data = $urandom;
      o_ready = $urandom_range(0, 99) < 65;
      flush   = $urandom_range(0, 99) < 6;
      wb_now  = (infl.size() != 0) && ($urandom_range(0, 99) < 40);
      wbck_valid = wb_now;
      if (wb_now) begin
        wbck_rdidx = infl[0].rdidx;
        wbck_rdwen = infl[0].rdwen;
        wbck_rdfpu = infl[0].rdfpu;
      end else begin
        wbck_rdidx = 5'($urandom_range(0, 7));
        {wbck_rdwen, wbck_rdfpu} = 2'($urandom);
      end
      #1;

      hazard = (i_rs1en && i_rs1fpu && busy(i_rs1idx)) ||
               (i_rs2en && i_rs2fpu && busy(i_rs2idx)) ||
               (i_rs3en && i_rs3fpu && busy(i_rs3idx)) ||
               (i_rdwen && i_rdfpu && busy(i_rdidx));
      cnt_after = infl.size() + ((held_v && o_ready && !exp_q[0].ill) ? 1 : 0);
      exp_rdy = !flush && !hazard && (cnt_after < 2) && (!held_v || o_ready);
      chk("i_ready", i_ready, exp_rdy);
      chk("o_valid", o_valid, held_v);
      chk("fpu_busy", fpu_busy, held_v || infl.size() != 0);
      chk("frf_idx", {frf_rs1idx, frf_rs2idx, frf_rs3idx}, {i_rs1idx, i_rs2idx, i_rs3idx});

      acc = i_valid && exp_rdy;
      if (wb_now) void'(infl.pop_front());
      if (held_v && o_ready) begin
        if (!exp_q[0].ill) infl.push_back('{exp_q[0].rdidx, exp_q[0].rdwen, exp_q[0].rdfpu});
        held_v = 0;
      end else if (held_v && flush) begin
        void'(exp_q.pop_front());
        held_v = 0;
      end
      if (acc) begin
        e.ftype = i_ftype;
        e.rm    = (i_rm == 3'b111) ? csr_frm : i_rm;
        e.ill   = (i_ftype == 5'd31) || (rounds(i_ftype) && e.rm >= 3'd5);
        e.op1   = i_rs1fpu ? frf_rs1_data : i_int_rs1;
        e.op2   = i_rs2fpu ? frf_rs2_data : 32'd0;
        e.op3   = i_rs3fpu ? frf_rs3_data : 32'd0;
        e.rdidx = i_rdidx;
        e.rdwen = i_rdwen;
        e.rdfpu = i_rdfpu;
        exp_q.push_back(e);
        held_v = 1;
      end
    end

    @(negedge clk);
    i_valid = 1'b0;
    wbck_valid = 1'b0;
    o_ready = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
